logic_serial_sequencer: RTL and testbench
=========================================

Name: logic_serial_sequencer

Overview:
Bit-serial controller that computes a WIDTH-bit bitwise logic operation (AND/OR/XOR/NOT A) by time-multiplexing a single instance of the team's combinational 1-bit slice logic_unit (inputs Ai, Bi, sel[1:0]; output Ei; sel 00=AND, 01=OR, 10=XOR, 11=NOT Ai). It accepts operands over a valid/ready request channel and sequences one bit per clock through the slice, LSB first. It returns the assembled word over a valid/ready result channel. It is the area-reduced alternative to the 32-slice parallel logic path in the ALU.

Parameters:
WIDTH, 32, operand/result width in bits; legal range 2..64. The bit counter is $clog2(WIDTH) bits wide.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start_valid  input  1  request valid
start_ready  output  1  block can accept a request
op_a  input  WIDTH  operand A, sampled at request handshake
op_b  input  WIDTH  operand B, sampled at request handshake
sel  input  2  operation select, sampled at request handshake
abort  input  1  synchronous cancel of an in-flight operation
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
result  output  WIDTH  computed word
zero  output  1  result == 0, valid while res_valid=1
busy  output  1  high in RUN or DONE

Behaviour:
- Single clock domain. Reset is asynchronous, active-low, applied on rst_n low, with synchronous deassertion handled upstream.
- Reset values: state=IDLE, start_ready=1, res_valid=0, result=0, zero=0, busy=0, all internal shift registers and the counter cleared.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - start_ready=1.
  - On start_valid & start_ready: latch op_a→sa, op_b→sb, sel→sel_q; clear cnt; clear result; go to RUN.
- RUN:
  - start_ready=0. The slice is driven with Ai=sa[0], Bi=sb[0], sel=sel_q.
  - Each edge: sa and sb shift right by 1. result shifts right by 1 with Ei entering at result[WIDTH-1]. cnt increments.
  - When cnt==WIDTH-1 on that edge (last bit captured), go to DONE.
  - Result bit i therefore equals slice(op_a[i], op_b[i]). For sel=11, op_b is ignored.
- DONE:
  - res_valid=1. result and zero are held stable. zero = ~|result, registered when entering DONE.
  - On res_valid & res_ready: go to IDLE; res_valid drops on the same edge. result keeps its value until the next accepted request.
- Latency: accept on edge E0 → res_valid high after edge E_WIDTH (exactly WIDTH cycles). Earliest next accept is the edge after the result handshake, i.e. minimum period WIDTH+2 cycles per operation.
- start_valid during RUN or DONE: ignored. Request-side inputs may change freely; only values at the handshake are used.
- abort in RUN: on the next edge go to IDLE, res_valid stays 0, result is cleared to 0, no result is produced. abort in IDLE or DONE has no effect; a DONE result must still be handshaked. abort and the last RUN bit on the same edge: abort wins.
- rst_n low mid-operation: immediate return to reset values. The partially computed word is discarded; the first request after reset computes correctly.
- cnt never exceeds WIDTH-1 and is reset to 0 on every accept.
- busy = (state != IDLE).

Test Plan:
- WIDTH=32, sel=00, A=F0F0_F0F0, B=FF00_FF00 → result=F000_F000, zero=0, res_valid rises exactly 32 cycles after the accept edge.
- sel=01, A=0000_00FF, B=8000_0000 → result=8000_00FF. Then sel=10 with A=B=DEAD_BEEF → result=0000_0000, zero=1.
- sel=11, A=0000_0000, B=FFFF_FFFF → result=FFFF_FFFF. Then sel=11, A=1234_5678 → result=EDCB_A987; B has no effect.
- Backpressure: hold res_ready=0 for 5 cycles in DONE while toggling start_valid → result held constant, start_ready=0, no new request accepted. Raise res_ready → IDLE next edge, next request accepted one cycle later.
- abort asserted at RUN cycle 10 → IDLE next edge, res_valid never asserts, result=0. A following request sel=00, A=B=FFFF_FFFF → result=FFFF_FFFF.
- rst_n pulsed low for 1 ns mid-RUN (cycle 17, between edges) → outputs take reset values immediately. After release, request sel=10, A=AAAA_AAAA, B=5555_5555 → result=FFFF_FFFF.

Source files
------------

// File: rtl/logic_serial_sequencer.sv
// Bit-serial bitwise logic engine: one 1-bit logic slice is reused once per clock,
// LSB first, to build a WIDTH-bit AND/OR/XOR/NOT-A result behind valid/ready channels.
module logic_serial_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       sel,
    input  logic             abort,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Combinational 1-bit slice: 00=AND, 01=OR, 10=XOR, 11=NOT Ai.
    function automatic logic logic_unit(input logic ai, input logic bi, input logic [1:0] op);
        logic ei;
        case (op)
            2'b00:   ei = ai & bi;
            2'b01:   ei = ai | bi;
            2'b10:   ei = ai ^ bi;
            2'b11:   ei = ~ai;
            default: ei = 1'b0;
        endcase
        return ei;
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   sa_r;
    logic [WIDTH-1:0]   sb_r;
    logic [1:0]         sel_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   result_r;
    logic               zero_r;
    logic               start_ready_r;
    logic               res_valid_r;
    logic               busy_r;
    logic               accept_s;
    logic               ei_s;
    logic [WIDTH-1:0]   result_shift_s;

    assign ei_s           = logic_unit(sa_r[0], sb_r[0], sel_r);
    assign result_shift_s = {ei_s, result_r[WIDTH-1:1]};

    // Next-state decode; abort takes priority over the last RUN bit.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_valid && start_ready_r) begin
                    state_s  = RUN;
                    accept_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_s = IDLE;
                end else if (cnt_r == LAST_BIT) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and handshake flags, all decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            start_ready_r <= 1'b1;
            res_valid_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            start_ready_r <= (state_s == IDLE);
            res_valid_r   <= (state_s == DONE);
            busy_r        <= (state_s != IDLE);
        end
    end

    // Operand shifters, bit counter and result assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_r     <= {WIDTH{1'b0}};
            sb_r     <= {WIDTH{1'b0}};
            sel_r    <= 2'b00;
            cnt_r    <= {CNT_W{1'b0}};
            result_r <= {WIDTH{1'b0}};
            zero_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        sa_r     <= op_a;
                        sb_r     <= op_b;
                        sel_r    <= sel;
                        cnt_r    <= {CNT_W{1'b0}};
                        result_r <= {WIDTH{1'b0}};
                        zero_r   <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        cnt_r    <= {CNT_W{1'b0}};
                        result_r <= {WIDTH{1'b0}};
                        zero_r   <= 1'b0;
                    end else begin
                        sa_r     <= {1'b0, sa_r[WIDTH-1:1]};
                        sb_r     <= {1'b0, sb_r[WIDTH-1:1]};
                        result_r <= result_shift_s;
                        // Counter parks at the last index so it never exceeds WIDTH-1.
                        if (cnt_r == LAST_BIT) begin
                            zero_r <= ~|result_shift_s;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    result_r <= result_r;
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign start_ready = start_ready_r;
    assign res_valid   = res_valid_r;
    assign busy        = busy_r;
    assign result      = result_r;
    assign zero        = zero_r;

endmodule

// File: tb/tb_logic_serial_sequencer.sv
// Scoreboard bench for logic_serial_sequencer: expected words are queued at request
// time from a word-level model and popped by a monitor at each result handshake.
module tb_logic_serial_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic [1:0]   sel = 2'b00;
    logic         abort = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] result;
    logic         zero;
    logic         busy;

    int checks = 0;
    int errors = 0;
    logic [W:0] exp_q[$];

    logic_serial_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
        .op_a(op_a), .op_b(op_b), .sel(sel), .abort(abort), .res_valid(res_valid),
        .res_ready(res_ready), .result(result), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] s);
        case (s)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_start_ready"}, 64'(start_ready), 64'd1);
        check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        check({tag, "_result"}, 64'(result), 64'd0);
        check({tag, "_zero"}, 64'(zero), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    // Monitor: a result handshake will occur on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'(result), 64'hDEAD);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("result", 64'(result), 64'(e[W-1:0]));
                check("zero", 64'(zero), 64'(e[W]));
            end
        end
    end

    // kill: 0 = normal, 1 = abort after kill_at RUN edges, 2 = reset pulse after kill_at edges
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s,
                         input int hold, input int kill, input int kill_at);
        logic [W-1:0] exp_w;
        int n;
        exp_w = model(a, b, s);
        n = 0;
        while (!start_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("ready_before_req", 64'(start_ready), 64'd1);
        op_a = a; op_b = b; sel = s; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0; op_a = $urandom; op_b = $urandom; sel = 2'($urandom);
        check("busy_after_accept", 64'({busy, start_ready}), 64'b10);
        if (kill == 1) begin
            repeat (kill_at) @(posedge clk);
            #1 abort = 1'b1;
            @(posedge clk); #1 abort = 1'b0;
            check("abort_state", 64'({res_valid, start_ready, busy}), 64'b010);
            check("abort_result", 64'(result), 64'd0);
            repeat (W + 2) @(posedge clk);
            #1 check("abort_no_valid", 64'(res_valid), 64'd0);
        end else if (kill == 2) begin
            repeat (kill_at) @(posedge clk);
            #2 rst_n = 1'b0;
            #1 check_reset_vals("midrun_reset");
            rst_n = 1'b1;
        end else begin
            exp_q.push_back({(exp_w == '0), exp_w});
            n = 0;
            while (!res_valid && n < W + 4) begin
                @(posedge clk); #1; n++;
            end
            check("latency", 64'(n), 64'(W));
            for (int i = 0; i < hold; i++) begin
                start_valid = 1'($urandom); op_a = $urandom; abort = 1'($urandom);
                @(posedge clk); #1;
                check("hold_result", 64'(result), 64'(exp_w));
                check("hold_flags", 64'({res_valid, start_ready, busy}), 64'b101);
            end
            start_valid = 1'b0; abort = 1'b0;
            res_ready = 1'b1;
            @(posedge clk); #1 res_ready = 1'b0;
            check("after_hs_flags", 64'({res_valid, start_ready, busy}), 64'b010);
            check("after_hs_result", 64'(result), 64'(exp_w));
        end
    endtask

    initial begin
        #7 check_reset_vals("reset");
        #5 rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(32'hF0F0_F0F0, 32'hFF00_FF00, 2'b00, 0, 0, 0);
        do_op(32'h0000_00FF, 32'h8000_0000, 2'b01, 0, 0, 0);
        do_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b10, 0, 0, 0);
        do_op(32'h0000_0000, 32'hFFFF_FFFF, 2'b11, 0, 0, 0);
        do_op(32'h1234_5678, 32'h0F0F_0F0F, 2'b11, 0, 0, 0);
        do_op(32'hA5A5_5A5A, 32'h3C3C_C3C3, 2'b10, 5, 0, 0);
        do_op(32'h1111_2222, 32'h3333_4444, 2'b01, 0, 1, 10);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 0, 0, 0);
        do_op(32'h1357_9BDF, 32'h2468_ACE0, 2'b10, 0, 1, W - 1);
        do_op(32'h0000_0001, 32'h8000_0001, 2'b00, 0, 0, 0);
        do_op(32'hCAFE_F00D, 32'h0BAD_BEEF, 2'b01, 0, 2, 17);
        do_op(32'hAAAA_AAAA, 32'h5555_5555, 2'b10, 0, 0, 0);
        for (int k = 0; k < 30; k++) begin
            int kl;
            kl = ($urandom_range(0, 7) == 0) ? 1 : 0;
            do_op($urandom, $urandom, 2'($urandom), $urandom_range(0, 3), kl,
                  $urandom_range(0, W - 1));
        end
        repeat (3) @(posedge clk);
        #1 check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
